fs_switch_sequencer: RTL and testbench
======================================

// Module: fs_switch_sequencer
// PURPOSE
// Sequences sample-rate changes and I2S (re)starts for the ADAT/USB bridge. On an fs_sel or resync
// request it mutes audio, stops I2S, switches the 44.1k/48k clock mux and resets the PLL. It then
// waits for PLL lock plus a settle time before restarting I2S. Sits between the MCU control pins
// and the clock mux / PLL / I2S engines in main.
// PARAMETERS
// SYNC_STAGES    2      flops in each input synchronizer (>=2)
// MUTE_CYCLES    256    clocks mute_o is held before I2S is stopped
// PLL_RST_CYCLES 16     clocks pll_rst_o is held in SWITCH
// SETTLE_CYCLES  4096   clocks of continuous lock required before I2S restart
// LOCK_TIMEOUT   65536  clocks allowed in PLL_WAIT before FAULT
// PORTS
// clk_i             in   1  free-running control clock
// rst_i             in   1  async, active-high reset
// mcu_ready_i       in   1  async; MCU ready for audio
// fs_sel_i          in   1  async; 0 = 48 kHz, 1 = 44.1 kHz
// i2s_resync_req_i  in   1  async; rising edge requests I2S resync
// pll_locked_i      in   1  async; PLL lock indicator
// clk_sel_o         out  1  clock mux select (0 = 48k, 1 = 44.1k)
// pll_rst_o         out  1  PLL reset
// mute_o            out  1  forces zero samples to I2S/ADAT outputs
// i2s_en_o          out  1  I2S engines enabled
// i2s_resync_o      out  1  one-clock pulse; I2S engines realign LRCLK/BCLK
// i2s_running_o     out  1  high only in RUN
// fault_o           out  1  PLL lock timeout
// state_o           out  4  state encoding, debug
// BEHAVIOUR
// - All async inputs pass SYNC_STAGES flops (reset 0) -> *_s. Resync edge = req_s & ~req_s_d.
// - Reset values: clk_sel_o=0, pll_rst_o=1, mute_o=1, i2s_en_o=0, i2s_resync_o=0,
//   i2s_running_o=0, fault_o=0, state=INIT(0). All outputs are registered.
// - Single down-counter sized $clog2 of the largest parameter; it is loaded on every state entry.
// - INIT(0): pll_rst_o=1, mute=1, en=0. mcu_ready_s=1 -> SWITCH.
// - SWITCH(1): clk_sel_o<=fs_sel_s on entry; pll_rst_o=1 for PLL_RST_CYCLES, then -> PLL_WAIT.
// - PLL_WAIT(2): pll_rst_o=0. pll_locked_s -> SETTLE. LOCK_TIMEOUT clocks expire -> FAULT.
// - SETTLE(3): lock lost -> SWITCH (retry). After SETTLE_CYCLES with lock held -> START.
// - START(4): one clock; i2s_en_o<=1, i2s_resync_o=1 for this clock only -> RUN.
// - RUN(5): mute_o=0, i2s_running_o=1. Any of fs_sel_s!=clk_sel_o, resync edge,
//   !pll_locked_s or !mcu_ready_s -> MUTE. mute_o=1 and i2s_running_o=0 on the first MUTE clock.
// - MUTE(6): mute_o=1 for MUTE_CYCLES -> STOP.
// - STOP(7): one clock; i2s_en_o<=0. Next state:
//   !mcu_ready_s -> INIT; fs or lock changed -> SWITCH; resync only -> START (no PLL reset).
// - FAULT(8): fault_o=1, pll_rst_o=1, mute=1, en=0. fs_sel_s change or resync edge -> SWITCH.
//   fault_o clears on leaving FAULT. !mcu_ready_s -> INIT.
// - PLL_WAIT/SETTLE: if fs_sel_s!=clk_sel_o -> SWITCH immediately with the new rate.
//   Resync edges in these states are ignored.
// - Resync-only requests are remembered in a flag (set in RUN, cleared in STOP).
//   Rate change plus resync in the same clock -> full rate-change path.
// - clk_sel_o changes only on SWITCH entry, never while i2s_en_o=1 or mute_o=0.
// - Latency: fs_sel_i edge -> mute_o=1 within SYNC_STAGES+2 clocks.
// - rst_i mid-operation: all outputs return to reset values asynchronously; the sequence restarts
//   from INIT.
// TESTING (MUTE=4, PLL_RST=2, SETTLE=8, TIMEOUT=32, SYNC=2)
// 1 Power-up: mcu_ready=1, fs_sel=0, lock 5 clk after pll_rst falls -> START then RUN.
//   i2s_resync_o is exactly 1 clock; mute_o=0 and i2s_running_o=1 in RUN.
// 2 In RUN, toggle fs_sel 0->1 -> MUTE 4 clk, STOP, clk_sel_o=1, pll_rst_o 2 clk, relock -> RUN.
//   Check i2s_en_o=0 whenever clk_sel_o changes.
// 3 In RUN, resync pulse, fs unchanged -> MUTE 4, STOP, START.
//   pll_rst_o stays 0 throughout; one i2s_resync_o pulse.
// 4 Never lock -> FAULT after 32 clk in PLL_WAIT, fault_o=1. A resync edge -> SWITCH, fault_o=0.
// 5 Drop lock at SETTLE count 5 -> SWITCH retry. Toggle fs_sel in PLL_WAIT -> SWITCH with new clk_sel.
// 6 Assert rst_i in SETTLE and in RUN -> outputs at reset values with no clk edge, state_o=0.

Source files
------------

// File: rtl/fs_switch_sequencer.sv
// Sample-rate switch / I2S restart sequencer: mutes and stops I2S, switches the clock mux,
// resets the PLL, waits for a settled lock and restarts I2S.
module fs_switch_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int MUTE_CYCLES    = 256,
    parameter int PLL_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 4096,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mcu_ready_i,
    input  logic       fs_sel_i,
    input  logic       i2s_resync_req_i,
    input  logic       pll_locked_i,
    output logic       clk_sel_o,
    output logic       pll_rst_o,
    output logic       mute_o,
    output logic       i2s_en_o,
    output logic       i2s_resync_o,
    output logic       i2s_running_o,
    output logic       fault_o,
    output logic [3:0] state_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(MUTE_CYCLES, PLL_RST_CYCLES), max2(SETTLE_CYCLES, LOCK_TIMEOUT));
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_SWITCH   = 4'd1,
        S_PLL_WAIT = 4'd2,
        S_SETTLE   = 4'd3,
        S_START    = 4'd4,
        S_RUN      = 4'd5,
        S_MUTE     = 4'd6,
        S_STOP     = 4'd7,
        S_FAULT    = 4'd8
    } state_t;

    // Each stage carries {mcu_ready, fs_sel, resync_req, pll_locked}.
    logic [3:0] sync_q [SYNC_STAGES];
    logic       mcu_s, fs_s, req_s, lock_s;
    logic       req_d_q;
    logic       resync_edge;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            req_d_q <= 1'b0;
        end else begin
            sync_q[0] <= {mcu_ready_i, fs_sel_i, i2s_resync_req_i, pll_locked_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            req_d_q <= req_s;
        end
    end

    assign {mcu_s, fs_s, req_s, lock_s} = sync_q[SYNC_STAGES-1];
    assign resync_edge = req_s & ~req_d_q;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   clk_sel_q, clk_sel_d;
    logic   pll_rst_q, pll_rst_d;
    logic   mute_q, mute_d;
    logic   en_q, en_d;
    logic   resync_q, resync_d;
    logic   running_q, running_d;
    logic   fault_q, fault_d;
    logic   relock_q, relock_d;
    logic   rsflag_q, rsflag_d;
    logic   fs_diff, cnt_zero;

    assign fs_diff  = (fs_s != clk_sel_q);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        relock_d  = relock_q;
        rsflag_d  = rsflag_q;
        clk_sel_d = clk_sel_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_INIT:     if (mcu_s) state_d = S_SWITCH;
            S_SWITCH:   if (cnt_zero) state_d = S_PLL_WAIT;
            S_PLL_WAIT: begin
                if (fs_diff)       state_d = S_SWITCH;
                else if (lock_s)   state_d = S_SETTLE;
                else if (cnt_zero) state_d = S_FAULT;
            end
            S_SETTLE: begin
                if (fs_diff || !lock_s) state_d = S_SWITCH;
                else if (cnt_zero)      state_d = S_START;
            end
            S_START:    state_d = S_RUN;
            S_RUN: begin
                if (fs_diff || !lock_s) relock_d = 1'b1;
                if (resync_edge)        rsflag_d = 1'b1;
                if (fs_diff || !lock_s || resync_edge || !mcu_s) state_d = S_MUTE;
            end
            S_MUTE:     if (cnt_zero) state_d = S_STOP;
            S_STOP: begin
                // A rate or lock problem always wins over a plain resync request.
                relock_d = 1'b0;
                rsflag_d = 1'b0;
                if (!mcu_s)                          state_d = S_INIT;
                else if (relock_q || fs_diff || !lock_s) state_d = S_SWITCH;
                else if (rsflag_q)                   state_d = S_START;
                else                                 state_d = S_SWITCH;
            end
            S_FAULT: begin
                if (!mcu_s)                      state_d = S_INIT;
                else if (fs_diff || resync_edge) state_d = S_SWITCH;
            end
            default:    state_d = S_INIT;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                S_SWITCH:   cnt_d = cnt_t'(PLL_RST_CYCLES - 1);
                S_PLL_WAIT: cnt_d = cnt_t'(LOCK_TIMEOUT - 1);
                S_SETTLE:   cnt_d = cnt_t'(SETTLE_CYCLES - 1);
                S_MUTE:     cnt_d = cnt_t'(MUTE_CYCLES - 1);
                default:    cnt_d = '0;
            endcase
            if (state_d == S_SWITCH) clk_sel_d = fs_s;
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - cnt_t'(1);
        end

        // Outputs are registered from the next state so they line up with state_o.
        pll_rst_d = state_d inside {S_INIT, S_SWITCH, S_FAULT};
        mute_d    = (state_d != S_RUN);
        en_d      = state_d inside {S_START, S_RUN, S_MUTE};
        resync_d  = (state_d == S_START);
        running_d = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            clk_sel_q <= 1'b0;
            pll_rst_q <= 1'b1;
            mute_q    <= 1'b1;
            en_q      <= 1'b0;
            resync_q  <= 1'b0;
            running_q <= 1'b0;
            fault_q   <= 1'b0;
            relock_q  <= 1'b0;
            rsflag_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_sel_q <= clk_sel_d;
            pll_rst_q <= pll_rst_d;
            mute_q    <= mute_d;
            en_q      <= en_d;
            resync_q  <= resync_d;
            running_q <= running_d;
            fault_q   <= fault_d;
            relock_q  <= relock_d;
            rsflag_q  <= rsflag_d;
        end
    end

    assign clk_sel_o     = clk_sel_q;
    assign pll_rst_o     = pll_rst_q;
    assign mute_o        = mute_q;
    assign i2s_en_o      = en_q;
    assign i2s_resync_o  = resync_q;
    assign i2s_running_o = running_q;
    assign fault_o       = fault_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fs_switch_sequencer.sv
// Bench for fs_switch_sequencer: PLL model, state-sequence scoreboard and per-scenario checks.
module tb_fs_switch_sequencer;

    localparam logic [3:0] S_INIT = 4'd0, S_SWITCH = 4'd1, S_PLL_WAIT = 4'd2, S_SETTLE = 4'd3,
                           S_START = 4'd4, S_RUN = 4'd5, S_MUTE = 4'd6, S_STOP = 4'd7, S_FAULT = 4'd8;
    localparam int LOCK_DELAY = 5;
    // {clk_sel, pll_rst, mute, en, resync, running, fault, state}
    localparam logic [10:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    logic       clk = 1'b0;
    logic       rst_i, mcu_ready_i, fs_sel_i, i2s_resync_req_i, pll_locked_i;
    logic       clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o;
    logic [3:0] state_o;

    logic [3:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         resync_pulses = 0;
    int         rs_len = 0;
    int         rst_hi = 0;
    bit         mon_en = 0;
    bit         pll_ok = 1;
    logic [3:0] prev_state;
    logic       prev_sel;

    fs_switch_sequencer #(
        .SYNC_STAGES(2), .MUTE_CYCLES(4), .PLL_RST_CYCLES(2), .SETTLE_CYCLES(8), .LOCK_TIMEOUT(32)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .mcu_ready_i(mcu_ready_i), .fs_sel_i(fs_sel_i),
        .i2s_resync_req_i(i2s_resync_req_i), .pll_locked_i(pll_locked_i),
        .clk_sel_o(clk_sel_o), .pll_rst_o(pll_rst_o), .mute_o(mute_o), .i2s_en_o(i2s_en_o),
        .i2s_resync_o(i2s_resync_o), .i2s_running_o(i2s_running_o), .fault_o(fault_o),
        .state_o(state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- PLL model: locks LOCK_DELAY clocks after reset release ----------------
    initial begin
        int lock_cnt;
        lock_cnt = 0;
        pll_locked_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_i || pll_rst_o !== 1'b0 || !pll_ok) begin
                lock_cnt = 0;
                pll_locked_i = 1'b0;
            end else if (lock_cnt < LOCK_DELAY) begin
                lock_cnt++;
            end else begin
                pll_locked_i = 1'b1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (state_o !== prev_state) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL state_seq: got unexpected state %0d, want no transition", state_o);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (state_o !== e) begin
                        errors++;
                        $display("FAIL state_seq: got %0d want %0d", state_o, e);
                    end
                end
                prev_state = state_o;
            end
            if (clk_sel_o !== prev_sel) begin
                checks++;
                if (i2s_en_o !== 1'b0 || mute_o !== 1'b1) begin
                    errors++;
                    $display("FAIL clk_sel_safe: en=%b mute=%b want en=0 mute=1", i2s_en_o, mute_o);
                end
                prev_sel = clk_sel_o;
            end
            if (i2s_resync_o === 1'b1) rs_len++;
            else if (rs_len != 0) begin
                checks++;
                if (rs_len != 1) begin
                    errors++;
                    $display("FAIL resync_width: got %0d want 1", rs_len);
                end
                resync_pulses++;
                rs_len = 0;
            end
            if (pll_rst_o === 1'b1) rst_hi++;
        end
    end

    // ---------------- helpers (no checking inside) ----------------
    task automatic wait_state(input logic [3:0] st, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (state_o === st) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic measure_state(input logic [3:0] st, output int n);
        n = 0;
        while (state_o === st && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic push_seq(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] s3, input logic [3:0] s4);
        exp_q.push_back(s0); exp_q.push_back(s1); exp_q.push_back(s2);
        exp_q.push_back(s3); exp_q.push_back(s4);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o, state_o} !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %b want %b",
                     {clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o, state_o}, RESET_VEC);
        end
        rst_i = 1'b0;
        prev_state = state_o;
        prev_sel = clk_sel_o;
        mon_en = 1;
        repeat (6) @(negedge clk);
        checks++;
        if (state_o !== S_INIT) begin
            errors++;
            $display("FAIL init_hold: got %0d want %0d", state_o, S_INIT);
        end
    endtask

    task automatic test_power_up;
        bit ok;
        int rs0;
        rs0 = resync_pulses;
        push_seq(S_SWITCH, S_PLL_WAIT, S_SETTLE, S_START, S_RUN);
        mcu_ready_i = 1'b1;
        wait_state(S_RUN, 200, ok);
        @(negedge clk);
        checks++;
        if (!ok || {mute_o, i2s_running_o, i2s_en_o, pll_rst_o, fault_o} !== 5'b01100) begin
            errors++;
            $display("FAIL power_up_run: got ok=%0d mute/run/en/rst/fault=%b want 1 01100", ok,
                     {mute_o, i2s_running_o, i2s_en_o, pll_rst_o, fault_o});
        end
        checks++;
        if (resync_pulses - rs0 != 1) begin
            errors++;
            $display("FAIL power_up_resync_count: got %0d want 1", resync_pulses - rs0);
        end
    endtask

    task automatic test_rate_change;
        bit ok;
        int n, rs0;
        rs0 = resync_pulses;
        push_seq(S_MUTE, S_STOP, S_SWITCH, S_PLL_WAIT, S_SETTLE);
        exp_q.push_back(S_START); exp_q.push_back(S_RUN);
        fs_sel_i = 1'b1;
        n = 0;
        while (mute_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 1 || n > 4) begin
            errors++;
            $display("FAIL fs_mute_latency: got %0d want 1..4", n);
        end
        measure_state(S_MUTE, n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL mute_cycles: got %0d want 4", n); end
        measure_state(S_STOP, n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL stop_cycles: got %0d want 1", n); end
        checks++;
        if (state_o !== S_SWITCH || clk_sel_o !== 1'b1 || pll_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL switch_entry: got state=%0d sel=%b rst=%b want 1 1 1", state_o, clk_sel_o, pll_rst_o);
        end
        measure_state(S_SWITCH, n);
        checks++;
        if (n != 2) begin errors++; $display("FAIL pll_rst_cycles: got %0d want 2", n); end
        wait_state(S_RUN, 200, ok);
        @(negedge clk);
        checks++;
        if (!ok || resync_pulses - rs0 != 1 || i2s_running_o !== 1'b1) begin
            errors++;
            $display("FAIL rate_change_run: got ok=%0d pulses=%0d run=%b want 1 1 1", ok, resync_pulses - rs0, i2s_running_o);
        end
    endtask

    task automatic test_resync;
        bit ok;
        int n, rs0;
        rs0 = resync_pulses;
        rst_hi = 0;
        exp_q.push_back(S_MUTE); exp_q.push_back(S_STOP); exp_q.push_back(S_START); exp_q.push_back(S_RUN);
        i2s_resync_req_i = 1'b1;
        wait_state(S_MUTE, 20, ok);
        measure_state(S_MUTE, n);
        checks++;
        if (!ok || n != 4) begin errors++; $display("FAIL resync_mute: got ok=%0d n=%0d want 1 4", ok, n); end
        measure_state(S_STOP, n);
        checks++;
        if (n != 1 || state_o !== S_START) begin
            errors++;
            $display("FAIL resync_stop_to_start: got n=%0d next=%0d want 1 %0d", n, state_o, S_START);
        end
        wait_state(S_RUN, 20, ok);
        @(negedge clk);
        i2s_resync_req_i = 1'b0;
        checks++;
        if (!ok || rst_hi != 0 || resync_pulses - rs0 != 1 || clk_sel_o !== 1'b1) begin
            errors++;
            $display("FAIL resync_path: got ok=%0d rst_hi=%0d pulses=%0d sel=%b want 1 0 1 1",
                     ok, rst_hi, resync_pulses - rs0, clk_sel_o);
        end
    endtask

    task automatic test_lock_timeout;
        bit ok;
        int n;
        push_seq(S_MUTE, S_STOP, S_SWITCH, S_PLL_WAIT, S_FAULT);
        push_seq(S_SWITCH, S_PLL_WAIT, S_SETTLE, S_START, S_RUN);
        pll_ok = 0;
        wait_state(S_PLL_WAIT, 100, ok);
        measure_state(S_PLL_WAIT, n);
        checks++;
        if (!ok || n != 32) begin errors++; $display("FAIL lock_timeout: got ok=%0d n=%0d want 1 32", ok, n); end
        repeat (5) @(negedge clk);
        checks++;
        if ({state_o, fault_o, pll_rst_o, mute_o, i2s_en_o, i2s_running_o} !== {S_FAULT, 5'b11100}) begin
            errors++;
            $display("FAIL fault_outputs: got %b want %b",
                     {state_o, fault_o, pll_rst_o, mute_o, i2s_en_o, i2s_running_o}, {S_FAULT, 5'b11100});
        end
        i2s_resync_req_i = 1'b1;
        wait_state(S_SWITCH, 20, ok);
        checks++;
        if (!ok || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL fault_exit: got ok=%0d fault=%b want 1 0", ok, fault_o);
        end
        i2s_resync_req_i = 1'b0;
        pll_ok = 1;
        wait_state(S_RUN, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fault_recover: got state %0d want %0d", state_o, S_RUN); end
    endtask

    task automatic test_settle_retry;
        bit ok;
        push_seq(S_MUTE, S_STOP, S_SWITCH, S_PLL_WAIT, S_SETTLE);
        exp_q.push_back(S_SWITCH); exp_q.push_back(S_PLL_WAIT);
        push_seq(S_SWITCH, S_PLL_WAIT, S_SETTLE, S_START, S_RUN);
        fs_sel_i = 1'b0;
        wait_state(S_SETTLE, 100, ok);
        repeat (4) @(negedge clk);
        pll_ok = 0;
        wait_state(S_SWITCH, 10, ok);
        checks++;
        if (!ok || clk_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL settle_retry: got ok=%0d sel=%b want 1 0", ok, clk_sel_o);
        end
        wait_state(S_PLL_WAIT, 10, ok);
        fs_sel_i = 1'b1;
        wait_state(S_SWITCH, 10, ok);
        checks++;
        if (!ok || clk_sel_o !== 1'b1) begin
            errors++;
            $display("FAIL pll_wait_fs_change: got ok=%0d sel=%b want 1 1", ok, clk_sel_o);
        end
        pll_ok = 1;
        wait_state(S_RUN, 200, ok);
        checks++;
        if (!ok || clk_sel_o !== 1'b1) begin
            errors++;
            $display("FAIL retry_run: got ok=%0d sel=%b want 1 1", ok, clk_sel_o);
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        push_seq(S_MUTE, S_STOP, S_SWITCH, S_PLL_WAIT, S_SETTLE);
        exp_q.push_back(S_INIT);
        fs_sel_i = 1'b0;
        wait_state(S_SETTLE, 100, ok);
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (!ok || {clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o, state_o} !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_settle: got ok=%0d %b want 1 %b", ok,
                     {clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o, state_o}, RESET_VEC);
        end
        repeat (3) @(negedge clk);
        push_seq(S_SWITCH, S_PLL_WAIT, S_SETTLE, S_START, S_RUN);
        exp_q.push_back(S_INIT);
        fs_sel_i = 1'b1;
        rst_i = 1'b0;
        wait_state(S_RUN, 200, ok);
        checks++;
        if (!ok || clk_sel_o !== 1'b1 || mute_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_after_reset: got ok=%0d sel=%b mute=%b want 1 1 0", ok, clk_sel_o, mute_o);
        end
        @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o, state_o} !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset_run: got %b want %b",
                     {clk_sel_o, pll_rst_o, mute_o, i2s_en_o, i2s_resync_o, i2s_running_o, fault_o, state_o}, RESET_VEC);
        end
        mcu_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (state_o !== S_INIT) begin
            errors++;
            $display("FAIL post_reset_idle: got %0d want %0d", state_o, S_INIT);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst_i = 1'b1;
        mcu_ready_i = 1'b0;
        fs_sel_i = 1'b0;
        i2s_resync_req_i = 1'b0;
        test_reset;
        test_power_up;
        test_rate_change;
        test_resync;
        test_lock_timeout;
        test_settle_retry;
        test_async_reset;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL seq_drained: got %0d pending states want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout at state %0d want end of test", state_o);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
